// File: rtl/csi_rx_hdr_ecc_chk.sv
// CSI-2 RX packet-header ECC checker/corrector with valid/ready pipeline (1 or 2 stages).
// Optional statistics counters are built when CSI_HDR_ECC_STATS_EN is defined.
module csi_rx_hdr_ecc_chk #(
  parameter int CNT_W   = 16,
  parameter int OUT_REG = 1
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_hdr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [23:0]      out_hdr,
  output logic             out_corr,
  output logic             out_err,
  output logic [1:0]       out_vcx,
  output logic [CNT_W-1:0] cnt_corr,
  output logic [CNT_W-1:0] cnt_err,
  input  logic             cnt_clr
);

  localparam logic [5:0] ECC_COL [24] = '{
    6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
    6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
    6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
  };

  function automatic logic [5:0] calc_ecc(input logic [23:0] d);
    logic [5:0] e;
    e = '0;
    for (int k = 0; k < 24; k++) begin
      if (d[k]) e = e ^ ECC_COL[k];
    end
    return e;
  endfunction

  // Stage 1: capture data, syndrome and VCX bits.
  logic        s1_valid_q;
  logic [23:0] s1_data_q;
  logic [5:0]  s1_syn_q;
  logic [1:0]  s1_vcx_q;
  logic        s1_adv;
  logic        in_fire;

  assign in_ready = !s1_valid_q | s1_adv;
  assign in_fire  = in_valid & in_ready;

  // NOTE: payload registers are reset too, because the outputs must read 0 out of reset.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_syn_q   <= '0;
      s1_vcx_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      s1_valid_q <= in_fire | (s1_valid_q & ~s1_adv);
      if (in_fire) begin
        s1_data_q <= in_hdr[23:0];
        s1_syn_q  <= in_hdr[29:24] ^ calc_ecc(in_hdr[23:0]);
        s1_vcx_q  <= in_hdr[31:30];
      end
    end
  end

  logic [23:0] fix_hdr;
  logic        fix_corr;
  logic        fix_err;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    fix_hdr  = s1_data_q;
    fix_corr = 1'b0;
    fix_err  = 1'b0;
    if (s1_syn_q != '0) begin
      if ((s1_syn_q & (s1_syn_q - 6'd1)) == '0) begin
        fix_corr = 1'b1;
      end else begin
        fix_err = 1'b1;
        for (int k = 0; k < 24; k++) begin
          if (s1_syn_q == ECC_COL[k]) begin
            fix_hdr[k] = ~s1_data_q[k];
            fix_corr   = 1'b1;
            fix_err    = 1'b0;
          end
        end
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic        s2_valid_q;
      logic [23:0] s2_hdr_q;
      logic        s2_corr_q;
      logic        s2_err_q;
      logic [1:0]  s2_vcx_q;

      assign s1_adv = s1_valid_q & (~s2_valid_q | out_ready);

      always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
          s2_valid_q <= 1'b0;
          s2_hdr_q   <= '0;
          s2_corr_q  <= 1'b0;
          s2_err_q   <= 1'b0;
          s2_vcx_q   <= '0;
        end else begin
          s2_valid_q <= s1_adv | (s2_valid_q & ~out_ready);
          if (s1_adv) begin
            s2_hdr_q  <= fix_hdr;
            s2_corr_q <= fix_corr;
            s2_err_q  <= fix_err;
            s2_vcx_q  <= s1_vcx_q;
          end
        end
      end

      assign out_valid = s2_valid_q;
      assign out_hdr   = s2_hdr_q;
      assign out_corr  = s2_corr_q;
      assign out_err   = s2_err_q;
      assign out_vcx   = s2_vcx_q;
    end else begin : g_out_comb
      assign s1_adv    = s1_valid_q & out_ready;
      assign out_valid = s1_valid_q;
      assign out_hdr   = fix_hdr;
      assign out_corr  = fix_corr;
      assign out_err   = fix_err;
      assign out_vcx   = s1_vcx_q;
    end
  endgenerate

`ifdef CSI_HDR_ECC_STATS_EN
  logic [CNT_W-1:0] cnt_corr_q, cnt_corr_d;
  logic [CNT_W-1:0] cnt_err_q, cnt_err_d;
  logic             out_fire;

  assign out_fire = out_valid & out_ready;

  always_comb begin
    cnt_corr_d = cnt_corr_q;
    cnt_err_d  = cnt_err_q;
    if (cnt_clr) begin
      cnt_corr_d = '0;
      cnt_err_d  = '0;
    end else if (out_fire) begin
      if (out_corr && (cnt_corr_q != '1)) cnt_corr_d = cnt_corr_q + 1'b1;
      if (out_err && (cnt_err_q != '1))   cnt_err_d  = cnt_err_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_corr_q <= '0;
      cnt_err_q  <= '0;
    end else begin
      cnt_corr_q <= cnt_corr_d;
      cnt_err_q  <= cnt_err_d;
    end
  end

  assign cnt_corr = cnt_corr_q;
  assign cnt_err  = cnt_err_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign cnt_corr       = '0;
  assign cnt_err        = '0;
`endif

endmodule

// File: tb/tb_csi_rx_hdr_ecc_chk.sv
// Randomised bench for csi_rx_hdr_ecc_chk: nearest-codeword decode model plus scoreboard.
module tb_csi_rx_hdr_ecc_chk;
  localparam int CNT_W   = 2;
  localparam int OUT_REG = 1;
  localparam int STAGES  = OUT_REG + 1;
`ifdef CSI_HDR_ECC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic             clk = 1'b0;
  logic             arst_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_hdr;
  logic             out_valid;
  logic             out_ready;
  logic [23:0]      out_hdr;
  logic             out_corr;
  logic             out_err;
  logic [1:0]       out_vcx;
  logic [CNT_W-1:0] cnt_corr;
  logic [CNT_W-1:0] cnt_err;
  logic             cnt_clr;

  csi_rx_hdr_ecc_chk #(.CNT_W(CNT_W), .OUT_REG(OUT_REG)) dut (
    .clk(clk), .arst_n(arst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_hdr(in_hdr),
    .out_valid(out_valid), .out_ready(out_ready), .out_hdr(out_hdr),
    .out_corr(out_corr), .out_err(out_err), .out_vcx(out_vcx),
    .cnt_corr(cnt_corr), .cnt_err(cnt_err), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] hdr;
    logic        corr;
    logic        err;
    logic [1:0]  vcx;
  } exp_t;

  localparam logic [5:0] COL [24] = '{
    6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
    6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
    6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
  };

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_pop = 0;
  bit run   = 1'b0;
  int mode  = 0;
  logic or_fixed  = 1'b1;
  logic clr_fixed = 1'b0;
  exp_t q[$];
  int   tq[$];
  logic [CNT_W-1:0] m_corr = '0;
  logic [CNT_W-1:0] m_err  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] ecc_of(input logic [23:0] d);
    logic [5:0] e = '0;
    for (int k = 0; k < 24; k++) if (d[k]) e = e ^ COL[k];
    return e;
  endfunction

  function automatic bit is_codeword(input logic [29:0] w);
    return ecc_of(w[23:0]) == w[29:24];
  endfunction

  // Decode by searching for the unique codeword within one bit flip of the received word.
  function automatic exp_t model(input logic [31:0] h);
    exp_t r;
    logic [29:0] w2;
    r.hdr = h[23:0]; r.corr = 1'b0; r.err = 1'b0; r.vcx = h[31:30];
    if (!is_codeword(h[29:0])) begin
      r.err = 1'b1;
      for (int i = 0; i < 30; i++) begin
        w2 = h[29:0] ^ (30'd1 << i);
        if (is_codeword(w2)) begin
          r.hdr = w2[23:0]; r.corr = 1'b1; r.err = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] mk(input logic [23:0] d, input logic [1:0] vcx, input int nflip);
    logic [29:0] w;
    int p1, p2;
    w  = {ecc_of(d), d};
    p1 = $urandom_range(0, 29);
    if (nflip >= 1) w[p1] = ~w[p1];
    if (nflip >= 2) begin
      p2 = $urandom_range(0, 28);
      if (p2 >= p1) p2++;
      w[p2] = ~w[p2];
    end
    return {vcx, w};
  endfunction

  always @(posedge clk) cyc++;

  // out_ready / cnt_clr driver: fixed, 1,0,0,1 pattern, or random.
  initial begin
    int ti = 0;
    logic [3:0] pat = 4'b1001;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    forever begin
      @(posedge clk); #2;
      case (mode)
        1: begin out_ready = pat[ti % 4]; ti++; cnt_clr = clr_fixed; end
        2: begin out_ready = ($urandom_range(0, 3) != 0); cnt_clr = ($urandom_range(0, 31) == 0); end
        default: begin out_ready = or_fixed; cnt_clr = clr_fixed; end
      endcase
    end
  end

  // Compare process: checks outputs each cycle, then advances the model for the coming edge.
  always @(negedge clk) begin
    logic ev, er;
    exp_t h;
    if (run && arst_n) begin
      h  = '0;
      ev = (q.size() > 0) && ((cyc - tq[0]) >= OUT_REG);
      er = (q.size() < STAGES) || out_ready;
      check("out_valid", out_valid, ev);
      check("in_ready", in_ready, er);
      check("cnt_corr", cnt_corr, m_corr);
      check("cnt_err", cnt_err, m_err);
      if (ev) begin
        h = q[0];
        check("out_hdr", out_hdr, h.hdr);
        check("out_corr", out_corr, h.corr);
        check("out_err", out_err, h.err);
        check("out_vcx", out_vcx, h.vcx);
      end
      if (ev && out_ready) begin
        if (STATS) begin
          if (h.corr && m_corr != CMAX) m_corr = m_corr + 1'b1;
          if (h.err && m_err != CMAX)   m_err  = m_err + 1'b1;
        end
        void'(q.pop_front());
        void'(tq.pop_front());
        n_pop++;
      end
      if (STATS && cnt_clr) begin m_corr = '0; m_err = '0; end
      if (in_valid && er) begin
        q.push_back(model(in_hdr));
        tq.push_back(cyc + 1);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the edge that accepted the header.
  task automatic send(input logic [31:0] h);
    logic acc = 1'b0;
    int n = 0;
    in_valid = 1'b1;
    in_hdr   = h;
    while (!acc && n < 500) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    check("send_timeout", acc, 1'b1);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk); n++;
    end
    #1;
    check("drain_timeout", q.size(), 0);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int p0;
    logic [31:0] dir [5] = '{32'h1205002B, 32'h1205000B, 32'h1305002B, 32'h12050028, 32'hD205002B};

    check("pin_clean", model(32'h1205002B), {24'h05002B, 1'b0, 1'b0, 2'd0});
    check("pin_d5",    model(32'h1205000B), {24'h05002B, 1'b1, 1'b0, 2'd0});
    check("pin_ecc0",  model(32'h1305002B), {24'h05002B, 1'b1, 1'b0, 2'd0});
    check("pin_dbl",   model(32'h12050028), {24'h050028, 1'b0, 1'b1, 2'd0});
    check("pin_vcx",   model(32'hD205002B), {24'h05002B, 1'b0, 1'b0, 2'd3});

    arst_n = 1'b0; in_valid = 1'b0; in_hdr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_hdr", out_hdr, 24'h0);
    check("rst_out_corr", out_corr, 1'b0);
    check("rst_out_err", out_err, 1'b0);
    check("rst_out_vcx", out_vcx, 2'd0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_cnt_corr", cnt_corr, '0);
    check("rst_cnt_err", cnt_err, '0);
    @(posedge clk); #2;
    arst_n = 1'b1;
    run    = 1'b1;
    @(posedge clk); #1;

    // Directed headers, back to back with out_ready held high.
    foreach (dir[i]) send(dir[i]);
    idle(1);
    drain();

    // Saturation and clear-over-increment priority.
    clr_fixed = 1'b1; @(posedge clk); #1; clr_fixed = 1'b0;
    repeat (5) send(mk(24'($urandom), 2'($urandom), 1));
    idle(1);
    drain();
    check("cnt_corr_sat", cnt_corr, STATS ? 32'd3 : 32'd0);
    or_fixed = 1'b0;
    send(mk(24'($urandom), 2'd0, 1));
    idle(3);
    or_fixed = 1'b1; clr_fixed = 1'b1;
    @(posedge clk); #1;
    clr_fixed = 1'b0;
    check("cnt_clr_prio", cnt_corr, 32'd0);
    drain();

    // Eight back-to-back headers against an out_ready pattern of 1,0,0,1.
    p0 = n_pop;
    mode = 1;
    for (int i = 0; i < 8; i++) send(mk(24'($urandom), 2'($urandom), $urandom_range(0, 2)));
    in_valid = 1'b0;
    drain();
    check("b2b_delivered", n_pop - p0, 8);
    mode = 0;

    // Random traffic, random back-pressure and occasional counter clears.
    mode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      send(mk(24'($urandom), 2'($urandom), $urandom_range(0, 2)));
    end
    in_valid = 1'b0;
    drain();
    mode = 0;

    // Reset with two headers in flight; a new header waits on the input across reset.
    or_fixed = 1'b0;
    @(posedge clk); #1;
    send(mk(24'($urandom), 2'd1, 1));
    send(mk(24'($urandom), 2'd2, 2));
    in_hdr = mk(24'h00ABCD, 2'd3, 0);
    #2;
    arst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_cnt_corr", cnt_corr, '0);
    check("mid_rst_cnt_err", cnt_err, '0);
    q.delete(); tq.delete();
    m_corr = '0; m_err = '0;
    or_fixed = 1'b1;
    @(posedge clk);
    @(posedge clk); #2;
    arst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) send(mk(24'($urandom), 2'($urandom), $urandom_range(0, 1)));
    idle(1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/csi_rx_hdr_ecc_chk.md
# csi_rx_hdr_ecc_chk

Pipelined CSI-2 packet-header ECC checker/corrector for the RX path, sitting between the lane aligner/byte packer and the packet decoder. Takes a 32-bit short/long packet header, recomputes the 6-bit Hamming ECC over the 24 header bits, and corrects any single-bit error. Flags uncorrectable errors and forwards the repaired header over a valid/ready stream. Supersedes the combinational ECC generator with back-pressure, error classification, a parameterised pipeline, and optional statistics counters.

## Interface
- `CNT_W`, 16: width of the statistics counters (used only with `CSI_HDR_ECC_STATS_EN`).
- `OUT_REG`, 1: 1 = registered output stage (latency 2); 0 = output taken directly from stage 1 (latency 1).
- `clk`  in  1  system clock; all logic is on this clock.
- `arst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  header word valid.
- `in_ready`  out  1  block can accept a header this cycle.
- `in_hdr`  in  32  `[7:0]`=DI, `[15:8]`=WC LSB, `[23:16]`=WC MSB, `[31:24]`=received ECC.
- `out_valid`  out  1  corrected header valid.
- `out_ready`  in  1  downstream accepts.
- `out_hdr`  out  24  corrected `{WC MSB, WC LSB, DI}`.
- `out_corr`  out  1  a single-bit error was found (data or ECC field) and handled.
- `out_err`  out  1  uncorrectable error; `out_hdr` is the uncorrected data.
- `out_vcx`  out  2  `in_hdr[31:30]`, passed through (CSI-2 v2 VCX bits).
- `cnt_corr`  out  CNT_W  saturating count of corrected headers.
- `cnt_err`  out  CNT_W  saturating count of uncorrectable headers.
- `cnt_clr`  in  1  synchronous clear of both counters.

## Operation
- Parity columns (syndrome bits `[5:0]`) per data bit d0..d23: 07 0B 0D 0E 13 15 16 19 1A 1C 23 25 26 29 2A 2C 31 32 34 38 1F 2F 37 3B (hex).
- Computed ECC = XOR of the columns of all set data bits. Syndrome S = `in_hdr[29:24]` ^ computed. `in_hdr[31:30]` is excluded from the ECC.
- Classification:
  - S=0: clean.
  - S has exactly one bit set: ECC-field error; data unchanged; `out_corr`=1.
  - S equals column k: flip data bit k; `out_corr`=1.
  - Any other S: `out_err`=1; data unchanged.
- `out_corr` and `out_err` are never both 1.
- Stage 1 registers data, S, and vcx.
- Stage 2 (OUT_REG=1) registers the corrected data and flags. With OUT_REG=0, correction is combinational from stage 1.
- Pipeline advance rules:
  - Each stage holds its contents while its successor is full and not advancing.
  - `in_ready` = !s1_valid | s1_advance.
  - No bubbles while `out_ready`=1; full throughput of 1 header/cycle.
- Outputs are stable while `out_valid` & !`out_ready`.

## Timing
- Reset: `in_ready`=1 (combinational from the empty pipe). `out_valid`, `out_hdr`, `out_corr`, `out_err`, `out_vcx` = 0. Counters = 0.
- Latency from input accept to `out_valid`: OUT_REG+1 cycles.
- A reset assertion mid-stream discards all in-flight headers immediately. The first header after release is accepted on the first rising edge with `arst_n`=1.
- Counters:
  - Increment on the output handshake (`out_valid`&`out_ready`), by 1 per flagged header.
  - Saturate at 2^CNT_W−1.
  - `cnt_clr` has priority over a simultaneous increment; the result is 0.

## Configuration
- `CSI_HDR_ECC_STATS_EN` defined: `cnt_corr`/`cnt_err` implemented as above.
- Not defined: no counter flops; `cnt_corr`/`cnt_err` tied to 0; `cnt_clr` ignored.

## Test plan
- Clean header 0x1205002B (DI 0x2B, WC 0x0500, ECC 0x12), `out_ready`=1 → after OUT_REG+1 cycles: `out_hdr`=0x05002B, `out_corr`=0, `out_err`=0, `out_vcx`=0.
- 0x1205000B (d5 flipped) → `out_hdr`=0x05002B, `out_corr`=1. 0x1305002B (ECC bit 0 flipped) → `out_hdr`=0x05002B, `out_corr`=1.
- 0x12050028 (d0,d1 flipped, S=0x0C) → `out_hdr`=0x050028, `out_err`=1, `out_corr`=0. 0xD205002B → `out_vcx`=3, clean.
- Back-to-back 8 headers with `out_ready` toggled 1,0,0,1,… → all 8 delivered in order, none duplicated or dropped. `in_ready` drops only while both stages are full and stalled.
- With STATS_EN and CNT_W=2: send 5 correctable headers → `cnt_corr`=3 (saturated). `cnt_clr` pulsed together with a 6th correctable handshake → `cnt_corr`=0.
- Assert `arst_n` with 2 headers in flight → `out_valid`=0 immediately, counters 0. No stale header is emitted after release.
